trace_neuron: RTL and testbench
===============================

Name: trace_neuron

Overview:
- Downstream consumer of a bank of linear-decay trace counters.
- On a trigger, snapshots all p_num_inputs traces (the time surface), then computes a weighted sum serially, one input per clock.
- Compares the sum against a programmable threshold and emits one spike/valid result per evaluation.
- Weights are held locally and written through a simple single-cycle write port.

Parameters:
- p_base_width, 6: width of each incoming trace value (unsigned).
- p_num_inputs, 8: number of trace channels.
- p_addr_width, 3: weight address width; must satisfy 2**p_addr_width >= p_num_inputs.
- p_weight_width, 8: weight width (signed two's complement).
- p_acc_width, 18: accumulator, potential and threshold width (signed).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_trigger  in  1  start-evaluation pulse (typically the OR of the channel events).
- i_ln  in  p_num_inputs*p_base_width  flattened traces; channel k occupies bits [k*p_base_width +: p_base_width].
- i_w_wr  in  1  weight write strobe.
- i_w_addr  in  p_addr_width  weight index.
- i_w_data  in  p_weight_width  signed weight value.
- i_threshold  in  p_acc_width  signed firing threshold, sampled in COMPARE.
- o_busy  out  1  high from SNAP through COMPARE.
- o_valid  out  1  one-cycle pulse when a result is ready.
- o_spike  out  1  one-cycle pulse, coincident with o_valid, when potential >= threshold.
- o_potential  out  p_acc_width  last computed weighted sum, held until the next result.

Behaviour:
- Reset is asynchronous, active-low. On reset:
  - state = IDLE;
  - all weights = 0, snapshot = 0, accumulator = 0, index = 0;
  - o_busy = 0, o_valid = 0, o_spike = 0, o_potential = 0.
- Reset asserted mid-evaluation aborts the evaluation; no o_valid is produced.
- State machine:
  - IDLE: on i_trigger -> SNAP. Otherwise stay.
  - SNAP (1 cycle): register all of i_ln into the snapshot; clear accumulator; index = 0 -> ACCUM.
  - ACCUM (p_num_inputs cycles): acc <= sat(acc + signed({1'b0,snap[index]}) * w[index]); index increments each cycle. After index = p_num_inputs-1 -> COMPARE.
  - COMPARE (1 cycle): o_potential <= acc; o_valid <= 1; o_spike <= (acc >= i_threshold) as a signed compare -> IDLE.
- Latency: i_trigger sampled high at edge T gives o_valid high for the cycle following edge T+p_num_inputs+2. Default total is 11 cycles, trigger to valid.
- o_valid and o_spike are registered outputs, each high for exactly one cycle.
- i_trigger while o_busy = 1 is ignored; there is no queueing.
- A trigger in the same cycle as the COMPARE exit is also ignored. A new evaluation needs i_trigger while in IDLE.
- Arithmetic:
  - Traces are zero-extended to signed; product width is p_base_width+p_weight_width+1.
  - Accumulation saturates to the signed p_acc_width range, both max and min. Saturation never wraps.
- Weight writes:
  - When i_w_wr = 1 and o_busy = 0, w[i_w_addr] <= i_w_data.
  - A write while busy is dropped.
  - A write to an address >= p_num_inputs is dropped.
  - A write in the same cycle as a trigger from IDLE is accepted; the new weight is used by that evaluation.
- Trace inputs change freely after SNAP; only the snapshot is used.

Optional Feature:
- Macro TRACE_NEURON_REFRACTORY_EN.
- When defined:
  - Adds parameter p_refractory (default 16) and a refractory down-counter.
  - The counter loads p_refractory on the cycle o_spike is asserted and then decrements to 0.
  - A trigger while the counter is nonzero is ignored, and no o_valid is produced.
  - Adds output o_refractory (1), high while the counter is nonzero. Its reset value is 0.
- When undefined: no counter and no port; triggers in IDLE are always accepted.

Decomposition:
- Package trace_neuron_pkg holds:
  - state encoding IDLE/SNAP/ACCUM/COMPARE;
  - the saturation bound constants, derived from p_acc_width;
  - the product-width constant.
- One sub-module, trace_mac_sat: a combinational signed multiply plus saturating add, with parameterised widths. The FSM, snapshot and weight registers stay in trace_neuron.

Test Plan:
- Reset default parameters, all weights 0, traces 63, threshold 1, trigger -> o_valid at T+11, o_potential = 0, o_spike = 0.
- Weights all 1, trace k = k (0..7), threshold 28 -> o_potential = 28, o_spike = 1; repeat with threshold 29 -> o_spike = 0.
- Weights all 127, traces all 63, p_acc_width forced to 12 -> o_potential = 2047 (saturated); weights all -128 -> o_potential = -2048.
- During ACCUM:
  - second i_trigger -> no extra o_valid;
  - i_w_wr to addr 0 with data 5 -> w[0] unchanged, confirmed by the next evaluation;
  - traces changed after SNAP -> result uses the snapshot values.
- i_rst_n low at cycle 4 of ACCUM -> all outputs 0 immediately; no o_valid after reset release until a new trigger.
- With TRACE_NEURON_REFRACTORY_EN and p_refractory 16: after a spike, a trigger at +5 cycles is ignored and o_refractory = 1; a trigger at +17 cycles evaluates normally.

Source files
------------

// File: rtl/trace_neuron_pkg.sv
// Shared types and width/bound helpers for the trace_neuron slice.
// The optional refractory feature lives in trace_neuron.sv under TRACE_NEURON_REFRACTORY_EN.
package trace_neuron_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SNAP    = 2'd1,
    ACCUM   = 2'd2,
    COMPARE = 2'd3
  } state_t;

  // Zero-extended trace (base+1 bits) times signed weight.
  function automatic int prod_width(input int base_w, input int weight_w);
    return base_w + weight_w + 1;
  endfunction

  function automatic longint sat_max(input int acc_w);
    return (longint'(1) <<< (acc_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int acc_w);
    return -(longint'(1) <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/trace_mac_sat.sv
// Combinational multiply-accumulate step: acc + trace*weight, clamped to the
// signed accumulator range so an overflow pins at the rail instead of wrapping.
module trace_mac_sat
  import trace_neuron_pkg::*;
#(
  parameter int p_base_width   = 6,
  parameter int p_weight_width = 8,
  parameter int p_acc_width    = 18
) (
  input  logic signed [p_acc_width-1:0]    acc_in,
  input  logic        [p_base_width-1:0]   trace,
  input  logic signed [p_weight_width-1:0] weight,
  output logic signed [p_acc_width-1:0]    acc_out
);

  localparam int c_prod_width = prod_width(p_base_width, p_weight_width);
  // One guard bit above the wider operand makes the sum exact before clamping.
  localparam int c_sum_width  = ((p_acc_width > c_prod_width) ? p_acc_width : c_prod_width) + 1;
  localparam logic signed [c_sum_width-1:0] c_sum_max = c_sum_width'(sat_max(p_acc_width));
  localparam logic signed [c_sum_width-1:0] c_sum_min = c_sum_width'(sat_min(p_acc_width));
  localparam logic signed [p_acc_width-1:0] c_acc_max = p_acc_width'(sat_max(p_acc_width));
  localparam logic signed [p_acc_width-1:0] c_acc_min = p_acc_width'(sat_min(p_acc_width));

  logic signed [c_prod_width-1:0] prod;
  logic signed [c_sum_width-1:0]  sum;

  always_comb begin
    prod = c_prod_width'($signed({1'b0, trace})) * c_prod_width'(weight);
    sum  = c_sum_width'(acc_in) + c_sum_width'(prod);
    if (sum > c_sum_max) begin
      acc_out = c_acc_max;
    end else if (sum < c_sum_min) begin
      acc_out = c_acc_min;
    end else begin
      acc_out = sum[p_acc_width-1:0];
    end
  end

endmodule

// File: rtl/trace_neuron.sv
// Snapshots a bank of trace counters on a trigger, forms a serial saturating
// weighted sum and compares it to a threshold. Optional: TRACE_NEURON_REFRACTORY_EN.
module trace_neuron
  import trace_neuron_pkg::*;
#(
  parameter int p_base_width   = 6,
  parameter int p_num_inputs   = 8,
  parameter int p_addr_width   = 3,
  parameter int p_weight_width = 8,
  parameter int p_acc_width    = 18
`ifdef TRACE_NEURON_REFRACTORY_EN
  , parameter int p_refractory = 16
`endif
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic                                   i_trigger,
  input  logic [p_num_inputs*p_base_width-1:0]   i_ln,
  input  logic                                   i_w_wr,
  input  logic [p_addr_width-1:0]                i_w_addr,
  input  logic signed [p_weight_width-1:0]       i_w_data,
  input  logic signed [p_acc_width-1:0]          i_threshold,
  output logic                                   o_busy,
  output logic                                   o_valid,
  output logic                                   o_spike,
  output logic signed [p_acc_width-1:0]          o_potential,
`ifdef TRACE_NEURON_REFRACTORY_EN
  output logic                                   o_refractory,
`endif
  output state_t                                 o_state
);

  localparam logic [p_addr_width-1:0] c_last_idx = p_addr_width'(p_num_inputs - 1);

  state_t                            state, state_nxt;
  logic        [p_base_width-1:0]    snap [p_num_inputs];
  logic signed [p_weight_width-1:0]  w    [p_num_inputs];
  logic signed [p_acc_width-1:0]     acc, acc_nxt;
  logic        [p_addr_width-1:0]    idx;
  logic                              trig_ok;
  logic                              fire;

  assign fire    = (acc >= i_threshold);
  assign o_busy  = (state != IDLE);
  assign o_state = state;

`ifdef TRACE_NEURON_REFRACTORY_EN
  localparam int c_refr_width = $clog2(p_refractory + 1);
  logic [c_refr_width-1:0] refr_cnt;

  assign trig_ok      = i_trigger && (refr_cnt == '0);
  assign o_refractory = (refr_cnt != '0);

  // Loads on the same edge that raises o_spike, so the flag and spike coincide.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      refr_cnt <= '0;
    end else if (state == COMPARE && fire) begin
      refr_cnt <= c_refr_width'(p_refractory);
    end else if (refr_cnt != '0) begin
      refr_cnt <= refr_cnt - c_refr_width'(1);
    end
  end
`else
  assign trig_ok = i_trigger;
`endif

  trace_mac_sat #(
    .p_base_width   (p_base_width),
    .p_weight_width (p_weight_width),
    .p_acc_width    (p_acc_width)
  ) u_mac (
    .acc_in  (acc),
    .trace   (snap[idx]),
    .weight  (w[idx]),
    .acc_out (acc_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trig_ok) state_nxt = SNAP;
      SNAP:    state_nxt = ACCUM;
      ACCUM:   if (idx == c_last_idx) state_nxt = COMPARE;
      COMPARE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc         <= '0;
      idx         <= '0;
      o_valid     <= 1'b0;
      o_spike     <= 1'b0;
      o_potential <= '0;
      for (int k = 0; k < p_num_inputs; k++) begin
        snap[k] <= '0;
        w[k]    <= '0;
      end
    end else begin
      o_valid <= 1'b0;
      o_spike <= 1'b0;
      // Weights are frozen for the whole evaluation; a write alongside the trigger still lands.
      if (i_w_wr && !o_busy && (32'(i_w_addr) < p_num_inputs)) begin
        w[i_w_addr] <= i_w_data;
      end
      case (state)
        SNAP: begin
          for (int k = 0; k < p_num_inputs; k++) begin
            snap[k] <= i_ln[k*p_base_width +: p_base_width];
          end
          acc <= '0;
          idx <= '0;
        end
        ACCUM: begin
          acc <= acc_nxt;
          idx <= idx + p_addr_width'(1);
        end
        COMPARE: begin
          o_potential <= acc;
          o_valid     <= 1'b1;
          o_spike     <= fire;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_neuron.sv
// Bench for trace_neuron: a default instance and a 12-bit accumulator instance
// share stimulus; results are scored against a queue fed by tables and a model.
module tb_trace_neuron;
  import trace_neuron_pkg::*;

  localparam int NI = 8;
  localparam int BW = 6;
  localparam int W  = 32;  // {spike18, pot18, spike12, pot12}

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_trigger = 1'b0;
  logic [NI*BW-1:0]    i_ln = '0;
  logic                i_w_wr = 1'b0;
  logic [2:0]          i_w_addr = '0;
  logic signed [7:0]   i_w_data = '0;
  logic signed [17:0]  thr = '0;
  logic signed [11:0]  thr12 = '0;

  logic                busy, valid, spike, n_busy, n_valid, n_spike;
  logic signed [17:0]  potential;
  logic signed [11:0]  n_potential;
  state_t              st, n_st;
`ifdef TRACE_NEURON_REFRACTORY_EN
  logic                refr, n_refr;
`endif

  trace_neuron dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trigger(i_trigger), .i_ln(i_ln),
    .i_w_wr(i_w_wr), .i_w_addr(i_w_addr), .i_w_data(i_w_data), .i_threshold(thr),
    .o_busy(busy), .o_valid(valid), .o_spike(spike), .o_potential(potential),
`ifdef TRACE_NEURON_REFRACTORY_EN
    .o_refractory(refr),
`endif
    .o_state(st)
  );

  trace_neuron #(.p_acc_width(12)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .i_trigger(i_trigger), .i_ln(i_ln),
    .i_w_wr(i_w_wr), .i_w_addr(i_w_addr), .i_w_data(i_w_data), .i_threshold(thr12),
    .o_busy(n_busy), .o_valid(n_valid), .o_spike(n_spike), .o_potential(n_potential),
`ifdef TRACE_NEURON_REFRACTORY_EN
    .o_refractory(n_refr),
`endif
    .o_state(n_st)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int              n_checks = 0;
  int              n_pass = 0;
  logic [W-1:0]    exp_q[$];
  int              w_model[NI];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if ((spike && !valid) || (n_spike && !n_valid))
        check("spike_without_valid", 1, 0);
      if (valid || n_valid) begin
        logic [W-1:0] e;
        check("valid_pair", n_valid, valid);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("spike", spike, e[31]);
          check("potential", potential, $signed(e[30:13]));
          check("spike12", n_spike, e[12]);
          check("potential12", n_potential, $signed(e[11:0]));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic longint model_pot(input logic [NI*BW-1:0] ln, input int width);
    longint acc = 0;
    longint mx = (longint'(1) <<< (width - 1)) - 1;
    longint mn = -mx - 1;
    for (int k = 0; k < NI; k++) begin
      acc += longint'(ln[k*BW +: BW]) * longint'(w_model[k]);
      if (acc > mx) acc = mx;
      if (acc < mn) acc = mn;
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] pack(input bit s, input longint p, input bit s12, input longint p12);
    logic [17:0] p18 = 18'(p);
    logic [11:0] q12 = 12'(p12);
    return {s, p18, s12, q12};
  endfunction

  function automatic logic [W-1:0] model_word(input logic [NI*BW-1:0] ln, input longint t, input longint t12);
    longint p = model_pot(ln, 18);
    longint p12 = model_pot(ln, 12);
    return pack(p >= t, p, p12 >= t12, p12);
  endfunction

  function automatic logic [NI*BW-1:0] make_ln(input bit ramp, input int v);
    logic [NI*BW-1:0] ln;
    for (int k = 0; k < NI; k++) ln[k*BW +: BW] = ramp ? BW'(k) : BW'(v);
    return ln;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_weight(input int addr, input int data);
    @(negedge clk);
    i_w_wr = 1'b1; i_w_addr = 3'(addr); i_w_data = 8'(data);
    @(negedge clk);
    i_w_wr = 1'b0;
    w_model[addr] = data;
  endtask

  task automatic set_all(input int data);
    for (int k = 0; k < NI; k++) write_weight(k, data);
  endtask

  // Returns on the negedge one cycle after the sampling edge (count 1).
  task automatic pulse_trigger();
    @(negedge clk); i_trigger = 1'b1;
    @(negedge clk); i_trigger = 1'b0;
  endtask

  task automatic start_eval(input logic [NI*BW-1:0] ln, input longint t, input longint t12, input logic [W-1:0] e);
    i_ln = ln; thr = 18'(t); thr12 = 12'(t12);
    exp_q.push_back(e);
    pulse_trigger();
  endtask

  task automatic wait_valid(input int cnt);
    int  c = cnt;
    bit  got = 0;
    while (c <= 30) begin
      if (valid) begin got = 1; break; end
      @(negedge clk); c++;
    end
    check("latency", got ? c : -1, 11);
  endtask

  typedef struct {
    int w; bit ramp; int tval; int thr; int thr12;
    int pot; bit spk; int pot12; bit spk12;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [NI*BW-1:0] ln;
    longint p, p12, t, t12;

    vecs[0] = '{0,    0, 63, 1,      1,     0,      0, 0,     0};
    vecs[1] = '{1,    1, 0,  28,     28,    28,     1, 28,    1};
    vecs[2] = '{1,    1, 0,  29,     29,    28,     0, 28,    0};
    vecs[3] = '{127,  0, 63, 64008,  2047,  64008,  1, 2047,  1};
    vecs[4] = '{-128, 0, 63, -64511, -2048, -64512, 0, -2048, 1};
    for (int k = 0; k < NI; k++) w_model[k] = 0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_spike", spike, 0);
    check("rst_potential", potential, 0);
    check("rst_state", st, IDLE);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 5; i++) begin
      set_all(vecs[i].w);
      start_eval(make_ln(vecs[i].ramp, vecs[i].tval), vecs[i].thr, vecs[i].thr12,
                 pack(vecs[i].spk, vecs[i].pot, vecs[i].spk12, vecs[i].pot12));
      wait_valid(1);
    end

    // busy-time trigger, write and trace change; trigger during COMPARE
    set_all(1);
    start_eval(make_ln(1, 0), 28, 28, pack(1, 28, 1, 28));
    repeat (3) @(negedge clk);                       // count 4: ACCUM
    i_trigger = 1'b1; i_w_wr = 1'b1; i_w_addr = 3'd0; i_w_data = 8'sd5;
    i_ln = make_ln(0, 63);
    @(negedge clk);
    i_trigger = 1'b0; i_w_wr = 1'b0;
    repeat (5) @(negedge clk);                       // count 10: COMPARE
    i_trigger = 1'b1;
    @(negedge clk);
    i_trigger = 1'b0;
    wait_valid(11);
    repeat (15) @(negedge clk);
    ln = make_ln(0, 1);
    start_eval(ln, 8, 8, model_word(ln, 8, 8));      // w[0] must still be 1
    wait_valid(1);

    // weight write in the trigger cycle is used by that evaluation
    ln = make_ln(1, 0);
    i_ln = ln; thr = 18'sd91; thr12 = 12'sd91;
    w_model[7] = 10;
    exp_q.push_back(model_word(ln, 91, 91));
    @(negedge clk);
    i_trigger = 1'b1; i_w_wr = 1'b1; i_w_addr = 3'd7; i_w_data = 8'sd10;
    @(negedge clk);
    i_trigger = 1'b0; i_w_wr = 1'b0;
    wait_valid(1);
    check("write_at_trigger_pot", potential, 91);

    // reset in the 4th ACCUM cycle aborts the evaluation
    pulse_trigger();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_spike", spike, 0);
    check("abort_potential", potential, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) w_model[k] = 0;
    repeat (20) @(negedge clk);
    ln = make_ln(0, 63);
    start_eval(ln, 0, 0, model_word(ln, 0, 0));      // weights cleared -> 0 >= 0
    wait_valid(1);

    // trigger shortly after a spike
    set_all(1);
    ln = make_ln(1, 0);
    start_eval(ln, 0, 0, model_word(ln, 0, 0));
    wait_valid(1);
    repeat (4) @(negedge clk);
`ifdef TRACE_NEURON_REFRACTORY_EN
    check("refractory_flag", refr, 1);
    pulse_trigger();
    repeat (14) @(negedge clk);
    check("refractory_clear", refr, 0);
`endif
    start_eval(ln, 5, 5, model_word(ln, 5, 5));
    wait_valid(1);

    // randomized evaluations against the model
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < NI; k++) write_weight(k, int'($urandom_range(0, 255)) - 128);
      for (int k = 0; k < NI; k++) ln[k*BW +: BW] = BW'($urandom_range(0, 63));
      p   = model_pot(ln, 18);
      p12 = model_pot(ln, 12);
      t   = p + longint'($urandom_range(0, 2)) - 1;
      t12 = p12 + longint'($urandom_range(0, 2)) - 1;
      if (t12 > 2047) t12 = 2047;
      if (t12 < -2048) t12 = -2048;
      start_eval(ln, t, t12, model_word(ln, t, t12));
      wait_valid(1);
    end

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
